// File: rtl/unshift_unit.sv
// unshift_unit: iterative inverse rotator.
// Takes a word that was rotated by amt_in positions in direction sel_in and
// restores it by rotating it back one bit per clock under a start/busy/done
// handshake. One word is processed at a time.
// Optional feature: define UNSHIFT_CHECK_EN to add round-trip checking
// (exp_in, match_out, mismatch_cnt_out). The core timing is the same in both builds.
module unshift_unit #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [AMT_W-1:0] amt_in,
    input  logic             sel_in,
    output logic [WIDTH-1:0] out_out,
    output logic             busy_out,
    output logic             done_out
`ifdef UNSHIFT_CHECK_EN
    ,
    input  logic [WIDTH-1:0] exp_in,
    output logic             match_out,
    output logic [7:0]       mismatch_cnt_out
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Single-position circular rotations; nothing is dropped or zero-filled.
    function automatic logic [WIDTH-1:0] rot_right1(input logic [WIDTH-1:0] w);
        return {w[0], w[WIDTH-1:1]};
    endfunction

    function automatic logic [WIDTH-1:0] rot_left1(input logic [WIDTH-1:0] w);
        return {w[WIDTH-2:0], w[WIDTH-1]};
    endfunction

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [WIDTH-1:0] work_r;
    logic [WIDTH-1:0] work_nxt_s;
    logic [AMT_W-1:0] cnt_r;
    logic [AMT_W-1:0] cnt_nxt_s;
    logic             dir_r;
    logic             dir_nxt_s;
    logic             busy_r;
    logic             done_r;
    logic             accept_s;
    logic             finish_s;

    // Next-state and datapath decode for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        state_nxt_s = state_r;
        work_nxt_s  = work_r;
        cnt_nxt_s   = cnt_r;
        dir_nxt_s   = dir_r;
        accept_s    = 1'b0;
        finish_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_in) begin
                    accept_s    = 1'b1;
                    work_nxt_s  = a_in;
                    cnt_nxt_s   = amt_in;
                    dir_nxt_s   = sel_in;
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == {AMT_W{1'b0}}) begin
                    // Terminal edge: no rotation, the word is already restored.
                    finish_s    = 1'b1;
                    state_nxt_s = ST_DONE;
                end else begin
                    // Undo the original direction: left-rotated words go right.
                    if (dir_r) begin
                        work_nxt_s = rot_left1(work_r);
                    end else begin
                        work_nxt_s = rot_right1(work_r);
                    end
                    cnt_nxt_s   = cnt_r - {{(AMT_W-1){1'b0}}, 1'b1};
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, working word and registered handshake outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r <= ST_IDLE;
            work_r  <= {WIDTH{1'b0}};
            cnt_r   <= {AMT_W{1'b0}};
            dir_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            work_r  <= work_nxt_s;
            cnt_r   <= cnt_nxt_s;
            dir_r   <= dir_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    assign out_out  = work_r;
    assign busy_out = busy_r;
    assign done_out = done_r;

`ifdef UNSHIFT_CHECK_EN
    logic [WIDTH-1:0] exp_r;
    logic             match_r;
    logic [7:0]       mismatch_cnt_r;

    // Round-trip check: capture the expectation on accept, judge the final word
    // on the edge that enters DONE, and count mismatches with saturation.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            exp_r          <= {WIDTH{1'b0}};
            match_r        <= 1'b0;
            mismatch_cnt_r <= 8'd0;
        end else begin
            if (accept_s) begin
                exp_r   <= exp_in;
                match_r <= 1'b0;
            end else if (finish_s) begin
                match_r <= (work_r == exp_r);
                if ((work_r != exp_r) && (mismatch_cnt_r != 8'hFF)) begin
                    mismatch_cnt_r <= mismatch_cnt_r + 8'd1;
                end else begin
                    mismatch_cnt_r <= mismatch_cnt_r;
                end
            end else begin
                match_r <= match_r;
            end
        end
    end

    assign match_out        = match_r;
    assign mismatch_cnt_out = mismatch_cnt_r;
`else
    // Handshake qualifiers are only consumed by the optional check logic.
    logic unused_s;
    assign unused_s = accept_s ^ finish_s;
`endif

endmodule

// File: tb/tb_unshift_unit.sv
// Directed self-checking bench for unshift_unit (WIDTH=8, AMT_W=3).
// Expected words, latencies and busy lengths are hand-computed constants.
// Define UNSHIFT_CHECK_EN on both RTL and bench to exercise the check outputs.
`timescale 1ns/1ps
module tb_unshift_unit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [2:0] amt;
    logic       sel;
    logic [7:0] out_w;
    logic       busy;
    logic       done;
`ifdef UNSHIFT_CHECK_EN
    logic [7:0] exp_w;
    logic       match;
    logic [7:0] mis_cnt;
`endif

    int checks = 0;
    int errors = 0;

    unshift_unit #(.WIDTH(8), .AMT_W(3)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .start_in (start),
        .a_in     (a),
        .amt_in   (amt),
        .sel_in   (sel),
        .out_out  (out_w),
        .busy_out (busy),
        .done_out (done)
`ifdef UNSHIFT_CHECK_EN
        ,
        .exp_in           (exp_w),
        .match_out        (match),
        .mismatch_cnt_out (mis_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Pulse start for one edge, then follow the operation to its done pulse.
    task automatic run_op(input string tag, input logic [7:0] a_v, input logic [2:0] amt_v,
                          input logic sel_v, input logic [7:0] exp_out, input int exp_lat);
        int lat;
        int busy_cnt;
        logic seen;
        lat = 0;
        busy_cnt = 0;
        seen = 1'b0;
        @(negedge clk);
        start = 1'b1;
        a = a_v;
        amt = amt_v;
        sel = sel_v;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, " done_seen"}, {31'd0, seen}, 32'd1);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " result"}, {24'd0, out_w}, {24'd0, exp_out});
        check({tag, " busy_len"}, busy_cnt, exp_lat + 1);
        @(posedge clk);
        @(negedge clk);
        check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, " busy_fall"}, {31'd0, busy}, 32'd0);
        check({tag, " held"}, {24'd0, out_w}, {24'd0, exp_out});
    endtask

    // Wait for done with a cycle bound, returning the number of edges waited.
    task automatic wait_done(output int lat, output logic seen);
        lat = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    initial begin
        int lat;
        logic seen;
        logic done_any;
        rst_n = 1'b0;
        start = 1'b0;
        a = 8'h00;
        amt = 3'd0;
        sel = 1'b0;
`ifdef UNSHIFT_CHECK_EN
        exp_w = 8'h00;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst out", {24'd0, out_w}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
`ifdef UNSHIFT_CHECK_EN
        check("rst match", {31'd0, match}, 32'd0);
        check("rst miscnt", {24'd0, mis_cnt}, 32'd0);
`endif

        // Directed vectors: original word F0 seen after left/right rotation.
        run_op("c3_l2", 8'hC3, 3'd2, 1'b0, 8'hF0, 3);
        run_op("3c_r2", 8'h3C, 3'd2, 1'b1, 8'hF0, 3);
        run_op("a5_0",  8'hA5, 3'd0, 1'b0, 8'hA5, 1);
        run_op("01_l7", 8'h01, 3'd7, 1'b0, 8'h02, 8);
        run_op("96_r3", 8'h96, 3'd3, 1'b1, 8'hB4, 4);
        run_op("80_r7", 8'h80, 3'd7, 1'b1, 8'h40, 8);

        // Start held high; inputs change mid-flight and must not be re-sampled.
        @(negedge clk);
        start = 1'b1;
        a = 8'h81;
        amt = 3'd1;
        sel = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 8'h10;
        amt = 3'd3;
        sel = 1'b0;
        check("hold e0 out", {24'd0, out_w}, 32'h81);
        @(posedge clk);
        @(negedge clk);
        check("hold e1 out", {24'd0, out_w}, 32'h03);
        @(posedge clk);
        @(negedge clk);
        check("hold e2 done", {31'd0, done}, 32'd1);
        check("hold e2 out", {24'd0, out_w}, 32'h03);
        @(posedge clk);
        @(negedge clk);
        check("hold e3 busy", {31'd0, busy}, 32'd0);
        check("hold e3 out", {24'd0, out_w}, 32'h03);
        @(posedge clk);
        @(negedge clk);
        check("hold e4 busy", {31'd0, busy}, 32'd1);
        check("hold e4 out", {24'd0, out_w}, 32'h10);
        start = 1'b0;
        wait_done(lat, seen);
        check("hold2 done_seen", {31'd0, seen}, 32'd1);
        check("hold2 latency", lat, 32'd4);
        check("hold2 result", {24'd0, out_w}, 32'h02);

        // Reset in the middle of SHIFT discards the word without a done pulse.
        @(negedge clk);
        start = 1'b1;
        a = 8'hB4;
        amt = 3'd5;
        sel = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mid busy", {31'd0, busy}, 32'd1);
        check("mid out", {24'd0, out_w}, 32'h2D);
        rst_n = 1'b0;
        #1;
        check("arst out", {24'd0, out_w}, 32'd0);
        check("arst busy", {31'd0, busy}, 32'd0);
        check("arst done", {31'd0, done}, 32'd0);
        done_any = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            done_any = done_any | done;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            done_any = done_any | done;
        end
        check("arst no_done", {31'd0, done_any}, 32'd0);
        check("arst idle", {31'd0, busy}, 32'd0);
        run_op("post_rst", 8'h3C, 3'd2, 1'b1, 8'hF0, 3);

`ifdef UNSHIFT_CHECK_EN
        exp_w = 8'hF0;
        run_op("chk_match", 8'hC3, 3'd2, 1'b0, 8'hF0, 3);
        check("chk match", {31'd0, match}, 32'd1);
        check("chk cnt0", {24'd0, mis_cnt}, 32'd0);
        exp_w = 8'h0F;
        run_op("chk_miss", 8'hC3, 3'd2, 1'b0, 8'hF0, 3);
        check("chk nomatch", {31'd0, match}, 32'd0);
        check("chk cnt1", {24'd0, mis_cnt}, 32'd1);
        for (int n = 0; n < 256; n++) begin
            @(negedge clk);
            start = 1'b1;
            a = 8'h5A;
            amt = 3'd0;
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            wait_done(lat, seen);
        end
        @(negedge clk);
        check("chk sat", {24'd0, mis_cnt}, 32'd255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
